// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the thermometer-mask helper used to build stall and flush masks.
package pipeline_hazard_ctrl_pkg;

  localparam int MAX_STAGES = 32;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } hazard_state_e;

  // Bits 0..n set; a negative n yields an empty mask.
  function automatic logic [MAX_STAGES-1:0] thermo_mask(input int n);
    logic [MAX_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_STAGES; i++) m[i] = (i <= n);
    return m;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_prio_enc.sv
// Highest-set-bit priority encoder; valid is low when no request bit is set.
module hazard_prio_enc #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt controller for the in-order pipeline (oldest requester wins).
// Optional per-stage stall cycle counters are enabled with PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDT_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_STAGES-1:0]      stall_req,
  input  logic [NUM_STAGES-1:0]      flush_req,
  input  logic [NUM_STAGES*XLEN-1:0] flush_pc,
  input  logic                       halt_req,
  output logic [NUM_STAGES-1:0]      stall,
  output logic [NUM_STAGES-1:0]      flush,
  output logic [NUM_STAGES-1:0]      bubble,
  output logic                       pc_stall,
  output logic                       pc_redirect,
  output logic [XLEN-1:0]            pc_redirect_addr,
  output logic                       halt_ack,
  output logic                       stall_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [NUM_STAGES*32-1:0]   stall_cycles
`endif
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_MAX = '1;

  hazard_state_e         state, next_state;
  logic [IW-1:0]         stall_idx, flush_idx, held_idx;
  logic                  stall_any, flush_any, accept;
  logic [NUM_STAGES-1:0] stall_mask, flush_new, held_mask;
  logic [CW-1:0]         hold_cnt;
  logic [WDT_WIDTH-1:0]  wdt;

  hazard_prio_enc #(.N(NUM_STAGES), .IW(IW)) u_stall_enc (
    .req(stall_req), .idx(stall_idx), .valid(stall_any)
  );

  hazard_prio_enc #(.N(NUM_STAGES), .IW(IW)) u_flush_enc (
    .req(flush_req), .idx(flush_idx), .valid(flush_any)
  );

  assign stall_mask = NUM_STAGES'(thermo_mask(int'(stall_idx)));
  assign flush_new  = NUM_STAGES'(thermo_mask(int'(flush_idx) - 1));

  // A flush must come from a stage older than every staller; during a hold
  // it must also be older than the flush already being held.
  always_comb begin
    accept = flush_any && (!stall_any || (flush_idx > stall_idx))
             && ((state != S_FLUSH) || (flush_idx > held_idx))
             && (state != S_HALT);
  end

  always_comb begin
    stall            = '0;
    flush            = '0;
    bubble           = '0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i == int'(flush_idx)) pc_redirect_addr = flush_pc[i*XLEN +: XLEN];
    end
    if (state == S_HALT) begin
      stall = '1;
    end else begin
      if (accept) begin
        flush       = flush_new;
        pc_redirect = 1'b1;
      end else if (state == S_FLUSH) begin
        flush = held_mask;
      end
      stall = stall_any ? (stall_mask & ~flush) : '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        bubble[i] = stall_any && (i == int'(stall_idx) + 1);
      end
    end
  end

  assign pc_stall      = |stall;
  // halt handshake: halt_req is a level; halt_ack is high exactly while frozen.
  assign halt_ack      = (state == S_HALT);
  assign stall_timeout = (wdt == WDT_MAX);

  always_comb begin
    next_state = state;
    case (state)
      S_RUN: begin
        if (accept && (FLUSH_CYCLES > 1))  next_state = S_FLUSH;
        else if (stall_any)                next_state = S_STALL;
        else if (halt_req && !flush_any)   next_state = S_HALT;
      end
      S_STALL: begin
        if (accept && (FLUSH_CYCLES > 1))  next_state = S_FLUSH;
        else if (!stall_any)               next_state = (halt_req && !flush_any) ? S_HALT : S_RUN;
      end
      S_FLUSH: begin
        if (!accept && (hold_cnt == CW'(1))) next_state = S_RUN;
      end
      S_HALT: begin
        if (!halt_req) next_state = S_RUN;
      end
      default: next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      held_mask <= '0;
      held_idx  <= '0;
      hold_cnt  <= '0;
      wdt       <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_FLUSH) begin
        if (accept) begin
          held_mask <= flush_new;
          held_idx  <= flush_idx;
          hold_cnt  <= HOLD_LOAD;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end else begin
        held_mask <= '0;
        held_idx  <= '0;
        hold_cnt  <= '0;
      end
      if (next_state == S_STALL) wdt <= (wdt == WDT_MAX) ? wdt : wdt + 1'b1;
      else                       wdt <= '0;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if ((state != S_HALT) && stall[i])
          stall_cycles[i*32 +: 32] <= stall_cycles[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run checked against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int NS = 5;
  localparam int XL = 32;

  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_FLUSH = 2;
  localparam int M_HALT  = 3;

  logic            clk;
  logic            rst_n;
  logic [NS-1:0]   stall_req, flush_req;
  logic [NS*XL-1:0] flush_pc;
  logic            halt_req;
  logic [NS-1:0]   stall, flush, bubble;
  logic            pc_stall, pc_redirect, halt_ack, stall_timeout;
  logic [XL-1:0]   pc_redirect_addr;
`ifdef PIPE_HAZARD_PERF_EN
  logic [NS*32-1:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_mode, m_hold_left, m_held_j, m_wdt, m_k, m_j;
  logic [4:0]  m_held_mask;
  bit          m_accept;
  logic [4:0]  e_stall, e_flush, e_bubble;
  logic        e_redirect, e_halt_ack, e_timeout;
  logic [XL-1:0] exp_q[$];

  pipeline_hazard_ctrl #(
    .NUM_STAGES(NS), .XLEN(XL), .FLUSH_CYCLES(3), .WDT_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_req(stall_req), .flush_req(flush_req), .flush_pc(flush_pc),
    .halt_req(halt_req),
    .stall(stall), .flush(flush), .bubble(bubble),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr),
    .halt_ack(halt_ack), .stall_timeout(stall_timeout)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL time_limit: bench still running at %0t, expected finish", $time);
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic do_reset;
    rst_n = 1'b0;
    stall_req = '0; flush_req = '0; halt_req = 1'b0; flush_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input int s, input logic [XL-1:0] v);
    flush_pc[s*XL +: XL] = v;
  endtask

  // behavioural model: derived from the stage-priority rules with plain arithmetic
  task automatic model_reset;
    m_mode = M_RUN; m_hold_left = 0; m_held_j = -1; m_held_mask = '0; m_wdt = 0;
    exp_q.delete();
  endtask

  task automatic model_eval;
    int k;
    int j;
    logic [4:0] fm, sraw;
    k = -1; j = -1;
    for (int i = 0; i < NS; i++) begin
      if (stall_req[i]) k = i;
      if (flush_req[i]) j = i;
    end
    m_k = k; m_j = j;
    m_accept = (m_mode != M_HALT) && (j >= 0) && (k < 0 || j > k) &&
               (m_mode != M_FLUSH || j > m_held_j);
    if (m_mode == M_HALT) begin
      e_stall = 5'b11111; e_bubble = '0; e_flush = '0;
    end else begin
      fm = m_accept ? 5'((1 << j) - 1) : ((m_mode == M_FLUSH) ? m_held_mask : 5'd0);
      sraw = (k < 0) ? 5'd0 : 5'((1 << (k + 1)) - 1);
      e_flush = fm;
      e_stall = sraw & ~fm;
      e_bubble = (k >= 0 && k < NS - 1) ? 5'(1 << (k + 1)) : 5'd0;
    end
    e_redirect = m_accept;
    if (m_accept) exp_q.push_back(flush_pc[j*XL +: XL]);
    e_halt_ack = (m_mode == M_HALT);
    e_timeout  = (m_wdt >= 7);
  endtask

  task automatic model_clock;
    case (m_mode)
      M_RUN, M_STALL: begin
        if (m_accept) begin
          m_mode = M_FLUSH; m_hold_left = 2; m_held_j = m_j;
          m_held_mask = 5'((1 << m_j) - 1);
        end else if (m_mode == M_RUN) begin
          if (m_k >= 0) m_mode = M_STALL;
          else if (halt_req && m_j < 0) m_mode = M_HALT;
        end else if (m_k < 0) begin
          m_mode = (halt_req && m_j < 0) ? M_HALT : M_RUN;
        end
      end
      M_FLUSH: begin
        if (m_accept) begin
          m_hold_left = 2; m_held_j = m_j; m_held_mask = 5'((1 << m_j) - 1);
        end else begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            m_mode = M_RUN; m_held_j = -1; m_held_mask = '0;
          end
        end
      end
      default: if (!halt_req) m_mode = M_RUN;
    endcase
    m_wdt = (m_mode == M_STALL) ? ((m_wdt < 7) ? m_wdt + 1 : 7) : 0;
  endtask

  // scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    stall_req = 5'b00101; flush_req = '0; halt_req = 1'b1; flush_pc = '0;
    @(negedge clk);
    n_cmp++; if (halt_ack !== 1'b0) begin n_bad++; $display("FAIL reset_halt_ack got %b want 0", halt_ack); end
    n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", stall_timeout); end
    n_cmp++; if (stall !== 5'b00111) begin n_bad++; $display("FAIL reset_comb_stall got %b want 00111", stall); end
    n_cmp++; if (flush !== 5'b00000 || pc_redirect !== 1'b0) begin
      n_bad++; $display("FAIL reset_flush got %b/%b want 00000/0", flush, pc_redirect); end
  endtask

  task automatic test_stall_priority;
    do_reset();
    stall_req = 5'b00101;
    @(negedge clk);
    n_cmp++; if (stall !== 5'b00111) begin n_bad++; $display("FAIL prio_stall got %b want 00111", stall); end
    n_cmp++; if (bubble !== 5'b01000) begin n_bad++; $display("FAIL prio_bubble got %b want 01000", bubble); end
    n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL prio_pc_stall got %b want 1", pc_stall); end
    next_cycle();
    stall_req = '0;
    @(negedge clk);
    n_cmp++; if (stall !== 5'b0 || bubble !== 5'b0 || pc_stall !== 1'b0) begin
      n_bad++; $display("FAIL prio_clear got %b/%b/%b want 0/0/0", stall, bubble, pc_stall); end
  endtask

  task automatic test_flush_accept;
    do_reset();
    set_pc(3, 32'h8000_1000);
    flush_req = 5'b01000;
    @(negedge clk);
    n_cmp++; if (flush !== 5'b00111) begin n_bad++; $display("FAIL acc_flush got %b want 00111", flush); end
    n_cmp++; if (pc_redirect !== 1'b1) begin n_bad++; $display("FAIL acc_redirect got %b want 1", pc_redirect); end
    n_cmp++; if (pc_redirect_addr !== 32'h8000_1000) begin
      n_bad++; $display("FAIL acc_addr got %h want 80001000", pc_redirect_addr); end
    next_cycle();
    flush_req = '0;
    @(negedge clk);
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL acc_one_shot got %b want 0", pc_redirect); end
    n_cmp++; if (flush !== 5'b00111) begin n_bad++; $display("FAIL acc_hold1 got %b want 00111", flush); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++; if (flush !== 5'b00000) begin n_bad++; $display("FAIL acc_hold_end got %b want 00000", flush); end
  endtask

  task automatic test_flush_defer;
    do_reset();
    set_pc(2, 32'h0000_4444);
    stall_req = 5'b10000; flush_req = 5'b00100;
    @(negedge clk);
    n_cmp++; if (flush !== 5'b0 || pc_redirect !== 1'b0) begin
      n_bad++; $display("FAIL defer_blocked got %b/%b want 00000/0", flush, pc_redirect); end
    n_cmp++; if (stall !== 5'b11111) begin n_bad++; $display("FAIL defer_stall got %b want 11111", stall); end
    next_cycle();
    stall_req = '0;
    @(negedge clk);
    n_cmp++; if (flush !== 5'b00011 || pc_redirect !== 1'b1) begin
      n_bad++; $display("FAIL defer_release got %b/%b want 00011/1", flush, pc_redirect); end
    n_cmp++; if (pc_redirect_addr !== 32'h0000_4444) begin
      n_bad++; $display("FAIL defer_addr got %h want 00004444", pc_redirect_addr); end
  endtask

  task automatic test_flush_hold;
    logic [4:0] want_flush [6];
    logic       want_redir [6];
    want_flush = '{5'b00011, 5'b00011, 5'b01111, 5'b01111, 5'b01111, 5'b00000};
    want_redir = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    set_pc(2, 32'h0000_2000);
    set_pc(4, 32'h0000_4000);
    for (int c = 0; c < 6; c++) begin
      flush_req = (c == 0) ? 5'b00100 : (c == 2) ? 5'b10000 : (c == 3) ? 5'b00010 : 5'b00000;
      @(negedge clk);
      n_cmp++; if (flush !== want_flush[c] || pc_redirect !== want_redir[c]) begin
        n_bad++; $display("FAIL hold_c%0d got %b/%b want %b/%b", c, flush, pc_redirect, want_flush[c], want_redir[c]); end
      if (c == 2) begin
        n_cmp++; if (pc_redirect_addr !== 32'h0000_4000) begin
          n_bad++; $display("FAIL hold_restart_addr got %h want 00004000", pc_redirect_addr); end
      end
      next_cycle();
    end
  endtask

  task automatic test_halt;
    do_reset();
    set_pc(3, 32'h1234_0000);
    stall_req = 5'b00001; halt_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) stall_req = '0;
      @(negedge clk);
      n_cmp++; if (halt_ack !== 1'b0) begin n_bad++; $display("FAIL halt_wait_c%0d got %b want 0", c, halt_ack); end
      next_cycle();
    end
    flush_req = 5'b01000;
    @(negedge clk);
    n_cmp++; if (halt_ack !== 1'b1) begin n_bad++; $display("FAIL halt_ack got %b want 1", halt_ack); end
    n_cmp++; if (stall !== 5'b11111 || bubble !== 5'b0 || pc_stall !== 1'b1) begin
      n_bad++; $display("FAIL halt_freeze got %b/%b/%b want 11111/00000/1", stall, bubble, pc_stall); end
    n_cmp++; if (flush !== 5'b0 || pc_redirect !== 1'b0) begin
      n_bad++; $display("FAIL halt_flush_ignored got %b/%b want 00000/0", flush, pc_redirect); end
    next_cycle();
    flush_req = '0; halt_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (halt_ack !== 1'b1) begin n_bad++; $display("FAIL halt_drop_same got %b want 1", halt_ack); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (halt_ack !== 1'b0) begin n_bad++; $display("FAIL halt_release got %b want 0", halt_ack); end
  endtask

  task automatic test_watchdog;
    do_reset();
    stall_req = 5'b00010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 6) begin
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL wdt_c6 got %b want 0", stall_timeout); end
      end
      if (c == 7) begin
        n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL wdt_c7 got %b want 1", stall_timeout); end
      end
      next_cycle();
    end
    stall_req = '0;
    @(negedge clk);
    n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL wdt_release_same got %b want 1", stall_timeout); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL wdt_release got %b want 0", stall_timeout); end
    next_cycle();
    stall_req = 5'b00100;
    repeat (9) next_cycle();
    n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL wdt_resat got %b want 1", stall_timeout); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL wdt_async_reset got %b want 0", stall_timeout); end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 6) begin
        n_cmp++; if (stall_timeout !== 1'b0) begin
          n_bad++; $display("FAIL wdt_restart got %b want 0", stall_timeout); end
      end
      next_cycle();
    end
  endtask

  task automatic test_random;
    logic [XL-1:0] got_addr;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        stall_req = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      flush_req = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
      if ($urandom_range(0, 7) == 0) flush_req = flush_req | 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      for (int s = 0; s < NS; s++) set_pc(s, $urandom);
      model_eval();
      @(negedge clk);
      n_cmp++; if (stall !== e_stall || bubble !== e_bubble || flush !== e_flush) begin
        n_bad++; $display("FAIL rnd_masks c%0d got %b/%b/%b want %b/%b/%b", c, stall, bubble, flush, e_stall, e_bubble, e_flush); end
      n_cmp++; if (pc_stall !== (|e_stall)) begin
        n_bad++; $display("FAIL rnd_pc_stall c%0d got %b want %b", c, pc_stall, |e_stall); end
      n_cmp++; if (pc_redirect !== e_redirect) begin
        n_bad++; $display("FAIL rnd_redirect c%0d got %b want %b", c, pc_redirect, e_redirect); end
      if (pc_redirect === 1'b1 && exp_q.size() > 0) begin
        got_addr = exp_q.pop_front();
        n_cmp++; if (pc_redirect_addr !== got_addr) begin
          n_bad++; $display("FAIL rnd_addr c%0d got %h want %h", c, pc_redirect_addr, got_addr); end
      end
      exp_q.delete();
      n_cmp++; if (halt_ack !== e_halt_ack || stall_timeout !== e_timeout) begin
        n_bad++; $display("FAIL rnd_status c%0d got %b/%b want %b/%b", c, halt_ack, stall_timeout, e_halt_ack, e_timeout); end
      model_clock();
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_flush_accept();
    test_flush_defer();
    test_flush_hold();
    test_halt();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
